// File: rtl/display_pkg.sv
// display_pkg: shared segment constants, digit index type and BCD segment table
package display_pkg;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  typedef logic [1:0] digit_idx_t;
  localparam logic [6:0] SEG_LUT [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, SEG_DASH,   SEG_DASH,
    SEG_DASH,   SEG_DASH,   SEG_DASH,   SEG_DASH
  };
endpackage

// File: rtl/bcd_to_7seg.sv
// bcd_to_7seg: combinational BCD to active-low {g..a} segment decode, non-BCD codes show a dash
module bcd_to_7seg
  import display_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);
  assign seg = SEG_LUT[bcd];
endmodule

// File: rtl/display_mux_7seg.sv
// display_mux_7seg: 4-digit multiplexed 7-segment driver with frame-coherent sampling and leading-zero blanking
module display_mux_7seg
  import display_pkg::*;
#(
  parameter int REFRESH_DIV = 50000,
  parameter int CNT_W       = 20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [15:0] bcd_in,
  input  logic [3:0]  dp_mask,
  input  logic        blank_lz,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an,
  output logic        frame_tick
);
  logic [CNT_W-1:0] cnt;
  digit_idx_t       idx;
  logic [15:0]      shadow;
  logic [3:0]       digit;
  logic [6:0]       dec;
  logic [3:0]       zero_above;
  logic             wrap;
  logic             blank;
  assign wrap  = enable && cnt == CNT_W'(REFRESH_DIV - 1);
  assign digit = shadow[{idx, 2'b00} +: 4];
  // zero_above[k] is set when digit k and every digit above it are zero
  always_comb begin
    zero_above[3] = shadow[15:12] == 4'd0;
    zero_above[2] = zero_above[3] && shadow[11:8] == 4'd0;
    zero_above[1] = zero_above[2] && shadow[7:4] == 4'd0;
    zero_above[0] = zero_above[1] && shadow[3:0] == 4'd0;
  end
  assign blank = blank_lz && idx != 2'd0 && zero_above[idx];
  bcd_to_7seg u_dec (
    .bcd (digit),
    .seg (dec)
  );
  // scan position; the shadow copy of bcd_in only refreshes at the frame boundary
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt        <= '0;
      idx        <= '0;
      shadow     <= '0;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= wrap && idx == 2'd3;
      if (enable) cnt <= wrap ? '0 : cnt + 1'b1;
      if (wrap) idx <= idx + 2'd1;
      if (wrap && idx == 2'd3) shadow <= bcd_in;
    end
  end
  // registered drive: dark when disabled or when the current digit is a blanked leading zero
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an  <= 4'b1111;
      seg <= SEG_BLANK;
      dp  <= 1'b1;
    end else begin
      an  <= (enable && !blank) ? ~(4'b0001 << idx) : 4'b1111;
      seg <= (enable && !blank) ? dec : SEG_BLANK;
      dp  <= (enable && !blank) ? ~dp_mask[idx] : 1'b1;
    end
  end
endmodule
